// File: rtl/bpsk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_pkg
// Purpose  : Shared encodings and state type for the BPSK demodulation sequencer.
// Revision : 1.0
// ============================================================================
package bpsk_pkg;

  localparam logic       MODE_HAMMING = 1'b0;
  localparam logic       MODE_BCH     = 1'b1;
  localparam logic [3:0] LEN_HAMMING  = 4'd8;
  localparam logic [3:0] LEN_BCH      = 4'd15;
  localparam logic [1:0] SYM_ZERO     = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Both rails equal means the channel could not decide the symbol.
  function automatic logic is_erasure(input logic [1:0] s);
    return (s == 2'b00) || (s == 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpsk_slicer.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_slicer
// Purpose  : Combinational hard decision of a 2-bit channel symbol plus erasure flag.
// Revision : 1.0
// ============================================================================
module bpsk_slicer
  import bpsk_pkg::*;
(
  input  logic [1:0] sym,
  output logic       data_bit,
  output logic       erasure
);

  assign data_bit = (sym == SYM_ZERO) ? 1'b0 : 1'b1;
  assign erasure  = is_erasure(sym);

endmodule
`default_nettype wire

// File: rtl/bpsk_demod_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_demod_ctrl
// Purpose  : Assembles sliced BPSK symbols into 8/15-bit codewords for the
//            downstream decoders. Define BPSK_ERASURE_EN to count erasures.
// Revision : 1.0
// ============================================================================
module bpsk_demod_ctrl
  import bpsk_pkg::*;
#(
  parameter int NMAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            flush,
  input  logic            sym_valid,
  input  logic [1:0]      sym,
  output logic            sym_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NMAX-1:0] data_out,
  output logic [3:0]      data_len,
  output logic [3:0]      erasure_cnt
);

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_cnt;
  logic [3:0]      r_len;
  logic [NMAX-1:0] r_shift;
  logic [NMAX-1:0] w_shift_upd;
  logic [3:0]      w_pos;
  logic            w_bit;
  logic            w_erasure;
  logic            w_accept;
  logic            w_first;
  logic            w_last;

  bpsk_slicer u_slicer (
    .sym      (sym),
    .data_bit (w_bit),
    .erasure  (w_erasure)
  );

  // Ready is decoded from the registered state so out_ready never reaches it.
  assign w_accept = sym_valid && (r_state != PRESENT) && !flush;
  assign w_first  = (r_state == IDLE);
  assign w_pos    = w_first ? 4'd0 : r_cnt;
  assign w_last   = (r_state == COLLECT) && (r_cnt == r_len - 4'd1);

  always_comb begin
    w_shift_upd        = w_first ? '0 : r_shift;
    w_shift_upd[w_pos] = w_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    sym_ready    = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        sym_ready = 1'b1;
        if (w_accept) w_state_next = COLLECT;
      end
      COLLECT: begin
        sym_ready = 1'b1;
        if (w_accept && w_last) w_state_next = PRESENT;
      end
      PRESENT: begin
        out_valid = !flush;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_len    <= LEN_HAMMING;
      r_shift  <= '0;
      data_out <= '0;
      data_len <= 4'd0;
    end else if (flush) begin
      r_cnt   <= 4'd0;
      r_shift <= '0;
    end else if (w_accept) begin
      r_shift <= w_shift_upd;
      r_cnt   <= w_pos + 4'd1;
      if (w_first) r_len <= (mode == MODE_BCH) ? LEN_BCH : LEN_HAMMING;
      if (w_last) begin
        data_out <= w_shift_upd;
        data_len <= r_len;
        r_cnt    <= 4'd0;
      end
    end
  end

`ifdef BPSK_ERASURE_EN
  logic [3:0] r_erase_acc;
  logic [3:0] w_erase_upd;

  assign w_erase_upd = (w_first ? 4'd0 : r_erase_acc) + {3'd0, w_erasure};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_erase_acc <= 4'd0;
      erasure_cnt <= 4'd0;
    end else if (flush) begin
      r_erase_acc <= 4'd0;
      erasure_cnt <= 4'd0;
    end else if (w_accept) begin
      r_erase_acc <= w_erase_upd;
      if (w_last) erasure_cnt <= w_erase_upd;
    end
  end
`else
  logic unused_erasure;
  assign unused_erasure = w_erasure;
  assign erasure_cnt    = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bpsk_demod_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpsk_demod_ctrl
// Purpose  : Directed scoreboard bench for bpsk_demod_ctrl.
// Revision : 1.0
// ============================================================================
module tb_bpsk_demod_ctrl;

`ifdef BPSK_ERASURE_EN
  localparam logic [3:0] C_ECNT = 4'd3;
`else
  localparam logic [3:0] C_ECNT = 4'd0;
`endif

  typedef struct packed {
    logic [14:0] d;
    logic [3:0]  l;
    logic [3:0]  e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mode = 1'b0;
  logic        flush = 1'b0;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym = 2'b00;
  logic        sym_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [14:0] data_out;
  logic [3:0]  data_len;
  logic [3:0]  erasure_cnt;

  exp_t        sb[$];
  logic [1:0]  pat [15];
  int          errors = 0;
  int          checks = 0;
  int          words_seen = 0;

  bpsk_demod_ctrl #(.NMAX(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .flush       (flush),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .sym_ready   (sym_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .data_len    (data_len),
    .erasure_cnt (erasure_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        words_seen++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h len=%0d ecnt=%0d with nothing expected",
                   data_out, data_len, erasure_cnt);
        end else begin
          e = sb.pop_front();
          if ({data_out, data_len, erasure_cnt} !== {e.d, e.l, e.e}) begin
            errors++;
            $display("FAIL word%0d: got data=%h len=%0d ecnt=%0d expected data=%h len=%0d ecnt=%0d",
                     words_seen, data_out, data_len, erasure_cnt, e.d, e.l, e.e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [14:0] d, input logic [3:0] l, input logic [3:0] e);
    exp_t x;
    x.d = d;
    x.l = l;
    x.e = e;
    sb.push_back(x);
  endtask

  // Drives pat[first..last]; mode m0 on frame symbol 0, m1 afterwards.
  task automatic send_frame(input int first, input int last, input logic m0, input logic m1);
    for (int k = first; k <= last; k++) begin
      int n;
      sym_valid = 1'b1;
      sym       = pat[k];
      mode      = (k == 0) ? m0 : m1;
      n = 0;
      while (!sym_ready && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 20) begin
        checks++;
        errors++;
        $display("FAIL sym_ready_timeout: got sym_ready=0 expected 1 at symbol %0d", k);
      end
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
  endtask

  task automatic wait_words(input int target);
    int n;
    n = 0;
    while (words_seen < target && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (words_seen < target) begin
      checks++;
      errors++;
      $display("FAIL word_timeout: got %0d words expected %0d", words_seen, target);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #3;
    chk("rst_sym_ready", sym_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_len", data_len, 0);
    chk("rst_erasure_cnt", erasure_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hamming frame, back-to-back symbols
    pat = '{default: 2'b01};
    pat[1] = 2'b10; pat[3] = 2'b10; pat[4] = 2'b10; pat[5] = 2'b10;
    push_exp(15'h003A, 4'd8, 4'd0);
    send_frame(0, 7, 1'b0, 1'b0);
    chk("ham_latency", out_valid, 1);
    wait_words(1);
    chk("ham_turnaround_ready", sym_ready, 1);

    // BCH frame with a 5-cycle downstream stall
    out_ready = 1'b0;
    pat = '{default: 2'b10};
    push_exp(15'h7FFF, 4'd15, 4'd0);
    send_frame(0, 14, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bch_stall", {out_valid, sym_ready, data_out, data_len}, {1'b1, 1'b0, 15'h7FFF, 4'd15});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_words(2);

    // Mode latched at the first symbol only
    for (int k = 0; k < 15; k++) pat[k] = (k % 2 == 0) ? 2'b10 : 2'b01;
    push_exp(15'h5555, 4'd15, 4'd0);
    send_frame(0, 7, 1'b1, 1'b0);
    chk("mode_no_early_valid", out_valid, 0);
    send_frame(8, 14, 1'b1, 1'b0);
    wait_words(3);

    // Flush on the 5th symbol of a Hamming frame
    pat = '{default: 2'b10};
    send_frame(0, 3, 1'b0, 1'b0);
    sym_valid = 1'b1;
    sym       = 2'b10;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    sym_valid = 1'b0;
    chk("flush_no_valid", out_valid, 0);
    chk("flush_idle_ready", sym_ready, 1);
    pat = '{default: 2'b01};
    pat[0] = 2'b10; pat[1] = 2'b10; pat[7] = 2'b10;
    push_exp(15'h0083, 4'd8, 4'd0);
    send_frame(0, 7, 1'b0, 1'b0);
    wait_words(4);

    // Erasures at positions 1..3
    pat = '{default: 2'b01};
    pat[1] = 2'b00; pat[2] = 2'b11; pat[3] = 2'b00;
    push_exp(15'h000E, 4'd8, C_ECNT);
    send_frame(0, 7, 1'b0, 1'b0);
    wait_words(5);

    // Asynchronous reset after 6 of 15 symbols
    pat = '{default: 2'b10};
    send_frame(0, 5, 1'b1, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("midrst_sym_ready", sym_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_data_len", data_len, 0);
    chk("midrst_erasure_cnt", erasure_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pat = '{default: 2'b10};
    for (int k = 0; k < 7; k++) pat[k] = 2'b01;
    push_exp(15'h7F80, 4'd15, 4'd0);
    send_frame(0, 14, 1'b1, 1'b1);
    wait_words(6);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
